// File: rtl/pipe_rs_hs.sv
// pipe_rs_hs: DEPTH-stage valid/ready register pipeline with a
// combinational ready chain, so empty stages absorb bubbles while the
// output is stalled. Synchronous active-high reset, synchronous flush.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   flush     in   synchronous clear of every stage valid bit
//   in_valid  in   upstream beat present
//   in_data   in   upstream beat payload [WIDTH]
//   in_ready  out  a beat is accepted this cycle when in_valid is high
//   out_valid out  downstream beat present
//   out_data  out  downstream beat payload [WIDTH] (last stage register)
//   out_ready in   downstream accepts a beat this cycle
//   count     out  number of occupied stages (0..DEPTH), registered
module pipe_rs_hs #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic [DEPTH-1:0] w_a;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [CW-1:0]    r_count;

  // Ready chain a[k] = !v[k] || a[k+1], a[DEPTH] = out_ready, evaluated
  // as a running OR from the output end so no vector feeds back on itself.
  always_comb begin : ready_chain
    logic w_acc;
    w_a   = '0;
    w_acc = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_acc              = w_acc || !w_v[DEPTH-1-i];
      w_a[DEPTH-1-i]     = w_acc;
    end
  end

  assign in_ready  = w_a[0] && !flush && !rst;
  assign out_valid = w_v[DEPTH-1] && !flush;
  assign out_data  = w_d[DEPTH-1];
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             r_v;
    logic [WIDTH-1:0] r_d;
    logic             w_vin;
    logic [WIDTH-1:0] w_din;

    if (g == 0) begin : g_head
      assign w_vin = w_in_hs;
      assign w_din = in_data;
    end else begin : g_body
      assign w_vin = w_v[g-1];
      assign w_din = w_d[g-1];
    end

    // A bubble moving in clears valid but keeps the old payload.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_d <= RST_DATA;
      end else if (flush) begin
        r_v <= 1'b0;
      end else if (w_a[g]) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_d <= w_din;
        end
      end
    end

    assign w_v[g] = r_v;
    assign w_d[g] = r_d;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_count <= r_count + CW'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign count = r_count;

endmodule
